// File: rtl/serial_device_arbiter_pkg.sv
// Shared definitions for the serial-device arbiter and the bridge it feeds:
// FSM state encoding and the Avalon-MM field widths of the serial slave.
package serial_device_arbiter_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_BUSY  = 3'd2,
    ST_DONE  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

endpackage

// File: rtl/serial_device_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first pending port found
// searching upward from last_grant+1 and wrapping at NUM_REQ-1 to 0.
module serial_device_arbiter_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int GRANT_W = 2
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [GRANT_W-1:0] last_grant,
  output logic               valid,
  output logic [GRANT_W-1:0] winner
);

  logic [GRANT_W-1:0] idx_s;

  // Walk the ports in priority order; the most recent winner is checked last.
  always_comb begin
    valid  = 1'b0;
    winner = last_grant;
    idx_s  = last_grant;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx_s = GRANT_W'((int'(last_grant) + i) % NUM_REQ);
      if (!valid && pending[idx_s]) begin
        valid  = 1'b1;
        winner = idx_s;
      end else begin
        valid  = valid;
      end
    end
  end

endmodule

// File: rtl/serial_device_arbiter.sv
// Shares one serial-device Avalon-MM slave between NUM_REQ masters.
// Round-robin grant held for a whole transaction, followed by an idle gap
// so the slave can return to its wait state before the next command.
module serial_device_arbiter
  import serial_device_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 3,
  parameter int GRANT_W    = 2
) (
  input  logic                      csi_MCLK_clk,
  input  logic                      rsi_MRST_reset,
  input  logic [NUM_REQ-1:0]        req_read,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
  input  logic [NUM_REQ*BE_W-1:0]   req_byteenable,
  output logic [NUM_REQ-1:0]        req_waitrequest,
  output logic [NUM_REQ-1:0]        req_readdatavalid,
  output logic [DATA_W-1:0]         req_readdata,
  output logic [ADDR_W-1:0]         avm_address,
  output logic [DATA_W-1:0]         avm_writedata,
  output logic [BE_W-1:0]           avm_byteenable,
  output logic                      avm_write,
  output logic                      avm_read,
  output logic                      avm_chipselect,
  input  logic                      avm_waitrequest,
  input  logic                      avm_readdatavalid,
  input  logic [DATA_W-1:0]         avm_readdata,
  output logic [GRANT_W-1:0]        grant_id,
  output logic                      busy
);

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  state_e               state_q, state_d;
  logic [GRANT_W-1:0]   last_grant_q, last_grant_d;
  logic [GRANT_W-1:0]   grant_q, grant_d;
  logic [7:0]           gap_q, gap_d;
  logic [ADDR_W-1:0]    cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]    cmd_wdata_q, cmd_wdata_d;
  logic [BE_W-1:0]      cmd_be_q, cmd_be_d;
  logic                 cmd_wr_q, cmd_wr_d;
  logic                 seen_wait_q, seen_wait_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 avm_read_q, avm_read_d;
  logic                 avm_write_q, avm_write_d;
  logic                 avm_cs_q, avm_cs_d;
  logic [NUM_REQ-1:0]   req_wait_q, req_wait_d;
  logic [NUM_REQ-1:0]   req_rdv_q, req_rdv_d;
  logic                 busy_q, busy_d;

  logic [NUM_REQ-1:0]   pending_s;
  logic                 pick_valid_s;
  logic [GRANT_W-1:0]   pick_idx_s;

  assign pending_s = req_read | req_write;

  serial_device_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GRANT_W (GRANT_W)
  ) u_rr_pick (
    .pending    (pending_s),
    .last_grant (last_grant_q),
    .valid      (pick_valid_s),
    .winner     (pick_idx_s)
  );

  // Transaction FSM: arbitration, command latch, completion tracking, gap timer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    gap_d        = gap_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    cmd_be_d     = cmd_be_q;
    cmd_wr_d     = cmd_wr_q;
    seen_wait_d  = seen_wait_q;
    rdata_d      = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_d      = ST_ISSUE;
          grant_d      = pick_idx_s;
          last_grant_d = pick_idx_s;
          cmd_addr_d   = req_address[int'(pick_idx_s)*ADDR_W +: ADDR_W];
          cmd_wdata_d  = req_writedata[int'(pick_idx_s)*DATA_W +: DATA_W];
          cmd_be_d     = req_byteenable[int'(pick_idx_s)*BE_W +: BE_W];
          // read+write together on one port is treated as a write
          cmd_wr_d     = req_write[pick_idx_s];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!avm_waitrequest) begin
          state_d     = ST_BUSY;
          seen_wait_d = 1'b0;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_BUSY: begin
        if (!cmd_wr_q) begin
          if (avm_readdatavalid) begin
            rdata_d = avm_readdata;
            state_d = ST_DONE;
          end else begin
            state_d = ST_BUSY;
          end
        end else begin
          // a write completes only once the slave has stalled and released
          if (seen_wait_q && !avm_waitrequest) begin
            state_d = ST_DONE;
          end else if (avm_waitrequest) begin
            seen_wait_d = 1'b1;
          end else begin
            seen_wait_d = seen_wait_q;
          end
        end
      end
      ST_DONE: begin
        gap_d   = GAP_LOAD;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    avm_cs_d    = (state_d == ST_ISSUE);
    avm_read_d  = (state_d == ST_ISSUE) && !cmd_wr_d;
    avm_write_d = (state_d == ST_ISSUE) && cmd_wr_d;
    busy_d      = (state_d != ST_IDLE);
    req_wait_d  = '1;
    req_rdv_d   = '0;
    for (int p = 0; p < NUM_REQ; p++) begin
      if ((state_d == ST_DONE) && (GRANT_W'(p) == grant_d)) begin
        req_wait_d[p] = 1'b0;
        req_rdv_d[p]  = !cmd_wr_d;
      end else begin
        req_wait_d[p] = 1'b1;
        req_rdv_d[p]  = 1'b0;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MRST_reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_W'(NUM_REQ - 1);
      grant_q      <= '0;
      gap_q        <= 8'd0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      cmd_be_q     <= '0;
      cmd_wr_q     <= 1'b0;
      seen_wait_q  <= 1'b0;
      rdata_q      <= '0;
      avm_read_q   <= 1'b0;
      avm_write_q  <= 1'b0;
      avm_cs_q     <= 1'b0;
      req_wait_q   <= '1;
      req_rdv_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      gap_q        <= gap_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      cmd_be_q     <= cmd_be_d;
      cmd_wr_q     <= cmd_wr_d;
      seen_wait_q  <= seen_wait_d;
      rdata_q      <= rdata_d;
      avm_read_q   <= avm_read_d;
      avm_write_q  <= avm_write_d;
      avm_cs_q     <= avm_cs_d;
      req_wait_q   <= req_wait_d;
      req_rdv_q    <= req_rdv_d;
      busy_q       <= busy_d;
    end
  end

  assign avm_address       = cmd_addr_q;
  assign avm_writedata     = cmd_wdata_q;
  assign avm_byteenable    = cmd_be_q;
  assign avm_read          = avm_read_q;
  assign avm_write         = avm_write_q;
  assign avm_chipselect    = avm_cs_q;
  assign req_waitrequest   = req_wait_q;
  assign req_readdatavalid = req_rdv_q;
  assign req_readdata      = rdata_q;
  assign grant_id          = grant_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_serial_device_arbiter.sv
// Directed bench for serial_device_arbiter with a behavioural serial slave.
module tb_serial_device_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int GAP_CYCLES = 3;
  localparam int GRANT_W    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req_read, req_write;
  logic [31:0]   req_address;
  logic [127:0]  req_writedata;
  logic [15:0]   req_byteenable;
  logic [3:0]    req_waitrequest, req_readdatavalid;
  logic [31:0]   req_readdata;
  logic [7:0]    avm_address;
  logic [31:0]   avm_writedata;
  logic [3:0]    avm_byteenable;
  logic          avm_write, avm_read, avm_chipselect;
  logic          avm_waitrequest, avm_readdatavalid;
  logic [31:0]   avm_readdata;
  logic [1:0]    grant_id;
  logic          busy;

  serial_device_arbiter #(
    .NUM_REQ(NUM_REQ), .GAP_CYCLES(GAP_CYCLES), .GRANT_W(GRANT_W)
  ) dut (
    .csi_MCLK_clk(clk), .rsi_MRST_reset(rst),
    .req_read(req_read), .req_write(req_write), .req_address(req_address),
    .req_writedata(req_writedata), .req_byteenable(req_byteenable),
    .req_waitrequest(req_waitrequest), .req_readdatavalid(req_readdatavalid),
    .req_readdata(req_readdata),
    .avm_address(avm_address), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_write(avm_write), .avm_read(avm_read),
    .avm_chipselect(avm_chipselect), .avm_waitrequest(avm_waitrequest),
    .avm_readdatavalid(avm_readdatavalid), .avm_readdata(avm_readdata),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // slave configuration (written by the stimulus process only)
  int          acc_stall = 0;
  int          busy_wait = 2;
  int          read_lat  = 3;
  logic [31:0] slv_rdata = 32'd0;

  // monitor / slave state (written by the monitor process only)
  int          cyc = 0, phase = 0, stall_cnt = 0, cnt = 0, idle_run = 0;
  logic        slv_is_wr = 1'b0;
  int          n_acc = 0;
  int          acc_port[64];
  logic [7:0]  acc_addr[64];
  logic        acc_wr[64];
  logic [31:0] acc_wd[64];
  logic [3:0]  acc_be[64];
  int          acc_idle[64];
  int          done_cnt[4], rdv_cnt[4], done_cyc[4];
  logic [31:0] rdv_data = 32'd0;
  int          wr_fall_cyc = 0, busy_fall_cyc = 0;
  int          wr_pulse_cnt = 0, cs_cnt = 0, unstable_cnt = 0, bad_cmd_cnt = 0;
  logic        busy_prev = 1'b0, prev_cs = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;
  logic [7:0]  prev_addr = 8'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_acc(input int target, input int max_cyc, input string tag);
    int k = 0;
    while (n_acc < target && k < max_cyc) begin tick(1); k++; end
    check_eq({tag, "_accept_seen"}, 32'(n_acc >= target), 32'd1);
  endtask

  task automatic wait_done(input int port, input int base, input int max_cyc, input string tag);
    int k = 0;
    while (done_cnt[port] <= base && k < max_cyc) begin tick(1); k++; end
    check_eq({tag, "_done_seen"}, 32'(done_cnt[port] > base), 32'd1);
  endtask

  // Behavioural serial slave plus bus monitor, evaluated on the falling edge.
  initial begin
    avm_waitrequest = 1'b1; avm_readdatavalid = 1'b0; avm_readdata = 32'd0;
    for (int p = 0; p < 4; p++) begin done_cnt[p] = 0; rdv_cnt[p] = 0; done_cyc[p] = 0; end
    forever begin
      @(negedge clk);
      cyc++;
      for (int p = 0; p < 4; p++) begin
        if (!req_waitrequest[p]) begin done_cnt[p]++; done_cyc[p] = cyc; end
        if (req_readdatavalid[p]) begin rdv_cnt[p]++; rdv_data = req_readdata; end
      end
      if (avm_write) wr_pulse_cnt++;
      if (avm_chipselect) cs_cnt++;
      if (((avm_read || avm_write) != avm_chipselect) || (avm_read && avm_write)) bad_cmd_cnt++;
      if (prev_cs && avm_chipselect &&
          (prev_addr != avm_address || prev_rd != avm_read || prev_wr != avm_write))
        unstable_cnt++;
      prev_cs = avm_chipselect; prev_addr = avm_address; prev_rd = avm_read; prev_wr = avm_write;
      if (busy_prev && !busy) busy_fall_cyc = cyc;
      busy_prev = busy;
      if (!avm_chipselect) idle_run++;
      avm_readdatavalid = 1'b0;
      if (rst) begin
        phase = 0; stall_cnt = 0; avm_waitrequest = 1'b1;
      end else if (phase == 0) begin
        if (avm_chipselect) begin
          if (stall_cnt < acc_stall) begin
            stall_cnt++; avm_waitrequest = 1'b1;
          end else begin
            avm_waitrequest = 1'b0;
            if (n_acc < 64) begin
              acc_port[n_acc] = int'(grant_id); acc_addr[n_acc] = avm_address;
              acc_wr[n_acc] = avm_write; acc_wd[n_acc] = avm_writedata;
              acc_be[n_acc] = avm_byteenable; acc_idle[n_acc] = idle_run;
            end
            n_acc++; idle_run = 0; stall_cnt = 0; cnt = 0;
            slv_is_wr = avm_write; phase = 1;
          end
        end else begin
          avm_waitrequest = 1'b1;
        end
      end else if (slv_is_wr) begin
        if (cnt < busy_wait) begin
          cnt++; avm_waitrequest = 1'b1;
        end else begin
          avm_waitrequest = 1'b0; wr_fall_cyc = cyc; phase = 0;
        end
      end else begin
        avm_waitrequest = 1'b1;
        if (cnt < read_lat) cnt++;
        else begin
          avm_readdatavalid = 1'b1; avm_readdata = slv_rdata; phase = 0;
        end
      end
    end
  end

  // Safety net: never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus and checks.
  initial begin
    int a0, b0, b1, b2, b3, c0, u0, w0, r0, r1, r2, r3;
    int exp_order[6];
    int min_idle;
    exp_order = '{0, 1, 2, 3, 0, 1};
    rst = 1'b1; req_read = 4'd0; req_write = 4'd0;
    req_address = 32'd0; req_writedata = 128'd0; req_byteenable = 16'd0;
    tick(3);

    // reset state
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_waitreq", 32'(req_waitrequest), 32'h0000000F);
    check_eq("rst_rdv", 32'(req_readdatavalid), 32'd0);
    check_eq("rst_grant", 32'(grant_id), 32'd0);
    check_eq("rst_cmd", 32'({avm_chipselect, avm_read, avm_write}), 32'd0);
    check_eq("rst_addr", 32'(avm_address), 32'd0);
    check_eq("rst_rdata", req_readdata, 32'd0);
    rst = 1'b0;
    tick(2);

    // single write on port 2, slave busy for 70 cycles
    busy_wait = 70; acc_stall = 0;
    a0 = n_acc; b2 = done_cnt[2]; w0 = wr_pulse_cnt;
    req_address[23:16] = 8'h10; req_writedata[95:64] = 32'hA5A5_0001;
    req_byteenable[11:8] = 4'hC; req_write[2] = 1'b1;
    wait_acc(a0 + 1, 20, "wr");
    req_write[2] = 1'b0;
    wait_done(2, b2, 200, "wr");
    tick(GAP_CYCLES + 3);
    check_eq("wr_port", 32'(acc_port[a0]), 32'd2);
    check_eq("wr_addr", 32'(acc_addr[a0]), 32'h10);
    check_eq("wr_isw", 32'(acc_wr[a0]), 32'd1);
    check_eq("wr_data", acc_wd[a0], 32'hA5A5_0001);
    check_eq("wr_be", 32'(acc_be[a0]), 32'hC);
    check_eq("wr_pulses", 32'(wr_pulse_cnt - w0), 32'd1);
    check_eq("wr_accepts", 32'(n_acc - a0), 32'd1);
    check_eq("wr_done_len", 32'(done_cnt[2] - b2), 32'd1);
    check_eq("wr_done_lat", 32'(done_cyc[2] - wr_fall_cyc), 32'd1);
    check_eq("wr_busy_drop", 32'(busy_fall_cyc - done_cyc[2]), 32'(GAP_CYCLES + 1));
    check_eq("wr_idle", 32'(busy), 32'd0);

    // single read on port 1
    read_lat = 3; slv_rdata = 32'h1234_5678;
    a0 = n_acc; b1 = done_cnt[1];
    r0 = rdv_cnt[0]; r1 = rdv_cnt[1]; r2 = rdv_cnt[2]; r3 = rdv_cnt[3];
    req_address[15:8] = 8'h04; req_read[1] = 1'b1;
    wait_acc(a0 + 1, 20, "rd");
    req_read[1] = 1'b0;
    wait_done(1, b1, 50, "rd");
    tick(GAP_CYCLES + 3);
    check_eq("rd_port", 32'(acc_port[a0]), 32'd1);
    check_eq("rd_addr", 32'(acc_addr[a0]), 32'h04);
    check_eq("rd_isw", 32'(acc_wr[a0]), 32'd0);
    check_eq("rd_rdv1", 32'(rdv_cnt[1] - r1), 32'd1);
    check_eq("rd_rdv_other", 32'((rdv_cnt[0] - r0) + (rdv_cnt[2] - r2) + (rdv_cnt[3] - r3)), 32'd0);
    check_eq("rd_data_at_valid", rdv_data, 32'h1234_5678);
    check_eq("rd_data_held", req_readdata, 32'h1234_5678);

    // contention: all ports write continuously from reset
    rst = 1'b1; tick(2);
    busy_wait = 2;
    for (int p = 0; p < 4; p++) req_address[p*8 +: 8] = 8'(8'h20 + p);
    req_write = 4'hF; rst = 1'b0;
    a0 = n_acc;
    wait_acc(a0 + 6, 300, "cont");
    req_write = 4'h0;
    tick(30);
    min_idle = 1000;
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("cont_order%0d", i), 32'(acc_port[a0 + i]), 32'(exp_order[i]));
      check_eq($sformatf("cont_addr%0d", i), 32'(acc_addr[a0 + i]), 32'(8'h20 + exp_order[i]));
      if (i > 0 && acc_idle[a0 + i] < min_idle) min_idle = acc_idle[a0 + i];
    end
    check_eq("cont_gap", 32'(min_idle >= GAP_CYCLES), 32'd1);
    check_eq("cont_no_overlap", 32'(bad_cmd_cnt), 32'd0);

    // acceptance stall of 5 cycles on a port 0 write
    acc_stall = 5; busy_wait = 1;
    a0 = n_acc; b0 = done_cnt[0]; c0 = cs_cnt; u0 = unstable_cnt; w0 = wr_pulse_cnt;
    req_address[7:0] = 8'h3C; req_write[0] = 1'b1;
    wait_acc(a0 + 1, 30, "stall");
    req_write[0] = 1'b0;
    wait_done(0, b0, 50, "stall");
    tick(GAP_CYCLES + 3);
    acc_stall = 0;
    check_eq("stall_accepts", 32'(n_acc - a0), 32'd1);
    check_eq("stall_cs_cycles", 32'(cs_cnt - c0), 32'd6);
    check_eq("stall_wr_cycles", 32'(wr_pulse_cnt - w0), 32'd6);
    check_eq("stall_stable", 32'(unstable_cnt - u0), 32'd0);
    check_eq("stall_addr", 32'(acc_addr[a0]), 32'h3C);
    check_eq("stall_done", 32'(done_cnt[0] - b0), 32'd1);

    // withdrawn read on port 3
    read_lat = 4; slv_rdata = 32'hCAFE_F00D;
    a0 = n_acc; b3 = done_cnt[3]; r3 = rdv_cnt[3];
    req_address[31:24] = 8'h7E; req_read[3] = 1'b1;
    tick(2);
    req_read[3] = 1'b0;
    wait_done(3, b3, 50, "wdr");
    tick(GAP_CYCLES + 3);
    check_eq("wdr_accepts", 32'(n_acc - a0), 32'd1);
    check_eq("wdr_port", 32'(acc_port[a0]), 32'd3);
    check_eq("wdr_done", 32'(done_cnt[3] - b3), 32'd1);
    check_eq("wdr_rdv", 32'(rdv_cnt[3] - r3), 32'd1);
    check_eq("wdr_data", rdv_data, 32'hCAFE_F00D);
    check_eq("wdr_idle", 32'(busy), 32'd0);

    // reset in the middle of a long read on port 2
    read_lat = 50;
    a0 = n_acc; r2 = rdv_cnt[2];
    req_read[2] = 1'b1;
    wait_acc(a0 + 1, 20, "mrst");
    req_read[2] = 1'b0;
    tick(3);
    check_eq("mrst_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick(1);
    check_eq("mrst_busy", 32'(busy), 32'd0);
    check_eq("mrst_waitreq", 32'(req_waitrequest), 32'h0000000F);
    check_eq("mrst_cs", 32'(avm_chipselect), 32'd0);
    check_eq("mrst_grant", 32'(grant_id), 32'd0);
    rst = 1'b0;
    read_lat = 2;
    a0 = n_acc;
    req_read[0] = 1'b1; req_read[1] = 1'b1;
    wait_acc(a0 + 1, 20, "post");
    req_read = 4'd0;
    tick(20);
    check_eq("post_first_grant", 32'(acc_port[a0]), 32'd0);
    check_eq("post_no_stale_rdv", 32'(rdv_cnt[2] - r2), 32'd0);
    check_eq("final_no_overlap", 32'(bad_cmd_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
